// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter for a single memory port.
// Each access runs IDLE -> BUSY (fixed read/write length) -> DONE (ack) -> IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_CYC = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic              iWe0,
  input  logic              iWe1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData0,
  input  logic [DATA_W-1:0] iWData1,
  output logic              oGnt0,
  output logic              oGnt1,
  output logic              oAck0,
  output logic              oAck1,
  output logic [DATA_W-1:0] oRData0,
  output logic [DATA_W-1:0] oRData1,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic              oMemWe,
  output logic              oMemRe,
  input  logic [DATA_W-1:0] iMemRData,
  output logic [1:0]        oState
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] RD_LOAD = 3'(RD_LAT - 1);
  localparam logic [2:0] WR_LOAD = 3'(WR_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic win_s;
  logic busy_s;
  logic done_s;

  // On a tie the requester that was not granted last time wins.
  assign win_s = (iReq0 & iReq1) ? ~last_q : iReq1;

  // Next-state logic: arbitration, access latching and read-data capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    we_d     = we_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (iReq0 | iReq1) begin
          state_d = S_BUSY;
          sel_d   = win_s;
          last_d  = win_s;
          we_d    = win_s ? iWe1 : iWe0;
          addr_d  = win_s ? iAddr1 : iAddr0;
          wdata_d = win_s ? iWData1 : iWData0;
          cnt_d   = (win_s ? iWe1 : iWe0) ? WR_LOAD : RD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (sel_q) begin
              rdata1_d = iMemRData;
            end else begin
              rdata0_d = iMemRData;
            end
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State registers; pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes decode only legal states, so the unreachable state drives all low.
  assign busy_s    = (state_q == S_BUSY);
  assign done_s    = (state_q == S_DONE);
  assign oGnt0     = (busy_s | done_s) & ~sel_q;
  assign oGnt1     = (busy_s | done_s) & sel_q;
  assign oAck0     = done_s & ~sel_q;
  assign oAck1     = done_s & sel_q;
  assign oMemRe    = busy_s & ~we_q;
  assign oMemWe    = busy_s & we_q;
  assign oMemAddr  = addr_q;
  assign oMemWData = wdata_q;
  assign oRData0   = rdata0_q;
  assign oRData1   = rdata1_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD/WR latencies 2/2, 1/7, 7/1) share
// stimulus and are checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic        iRST;
  logic        iReq0, iReq1, iWe0, iWe1;
  logic [31:0] iAddr0, iAddr1, iWData0, iWData1, iMemRData;

  logic [2:0]       g0, g1, a0, a1, mwe, mre;
  logic [2:0][1:0]  st;
  logic [2:0][31:0] ma, md, r0, r1;

  int vectors     = 0;
  int miscompares = 0;
  int RDL[3] = '{2, 1, 7};
  int WRL[3] = '{2, 7, 1};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .RD_LAT((g == 0) ? 2 : (g == 1) ? 1 : 7),
      .WR_CYC((g == 0) ? 2 : (g == 1) ? 7 : 1)
    ) u_dut (
      .iCLK(iCLK), .iRST(iRST),
      .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
      .iAddr0(iAddr0), .iAddr1(iAddr1), .iWData0(iWData0), .iWData1(iWData1),
      .oGnt0(g0[g]), .oGnt1(g1[g]), .oAck0(a0[g]), .oAck1(a1[g]),
      .oRData0(r0[g]), .oRData1(r1[g]),
      .oMemAddr(ma[g]), .oMemWData(md[g]), .oMemWe(mwe[g]), .oMemRe(mre[g]),
      .iMemRData(iMemRData), .oState(st[g])
    );
  end

  // Model: an access is a timeline k = 0..L-1 (strobe), k = L (ack), then free.
  bit          m_act[3], m_own[3], m_wr[3], m_last[3];
  int          m_k[3];
  logic [31:0] m_addr[3], m_wd[3], m_rd0[3], m_rd1[3];

  function automatic int acc_len(int i);
    return m_wr[i] ? WRL[i] : RDL[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_own[i] = 1'b0; m_wr[i] = 1'b0; m_last[i] = 1'b1; m_k[i] = 0;
      m_addr[i] = 32'd0; m_wd[i] = 32'd0; m_rd0[i] = 32'd0; m_rd1[i] = 32'd0;
    end
  endtask

  task automatic model_edge();
    bit w;
    for (int i = 0; i < 3; i++) begin
      if (m_act[i]) begin
        if (!m_wr[i] && m_k[i] == acc_len(i) - 1) begin
          if (m_own[i]) m_rd1[i] = iMemRData;
          else          m_rd0[i] = iMemRData;
        end
        if (m_k[i] == acc_len(i)) m_act[i] = 1'b0;
        else                      m_k[i]++;
      end else if (iReq0 || iReq1) begin
        w = (iReq0 && iReq1) ? !m_last[i] : iReq1;
        m_act[i] = 1'b1; m_k[i] = 0; m_own[i] = w; m_last[i] = w;
        m_wr[i]   = w ? iWe1 : iWe0;
        m_addr[i] = w ? iAddr1 : iAddr0;
        m_wd[i]   = w ? iWData1 : iWData0;
      end
    end
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit busy, done;
    for (int i = 0; i < 3; i++) begin
      busy = m_act[i] && (m_k[i] < acc_len(i));
      done = m_act[i] && (m_k[i] == acc_len(i));
      cmp($sformatf("u%0d gnt0", i), 32'(g0[i]), 32'(m_act[i] && !m_own[i]));
      cmp($sformatf("u%0d gnt1", i), 32'(g1[i]), 32'(m_act[i] && m_own[i]));
      cmp($sformatf("u%0d ack0", i), 32'(a0[i]), 32'(done && !m_own[i]));
      cmp($sformatf("u%0d ack1", i), 32'(a1[i]), 32'(done && m_own[i]));
      cmp($sformatf("u%0d memre", i), 32'(mre[i]), 32'(busy && !m_wr[i]));
      cmp($sformatf("u%0d memwe", i), 32'(mwe[i]), 32'(busy && m_wr[i]));
      cmp($sformatf("u%0d state", i), 32'(st[i]), busy ? 32'd1 : (done ? 32'd2 : 32'd0));
      cmp($sformatf("u%0d memaddr", i), ma[i], m_addr[i]);
      cmp($sformatf("u%0d memwdata", i), md[i], m_wd[i]);
      cmp($sformatf("u%0d rdata0", i), r0[i], m_rd0[i]);
      cmp($sformatf("u%0d rdata1", i), r1[i], m_rd1[i]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge iCLK);
    @(negedge iCLK);
    check_all();
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge iCLK);
    @(negedge iCLK);
    check_all();
    iRST = 1'b0;
  endtask

  int cg[3], cs[3], ca[3], co[3];
  bit prev_own;
  bit order[$];

  initial begin
    iRST = 1'b1; iReq0 = 1'b0; iReq1 = 1'b0; iWe0 = 1'b0; iWe1 = 1'b0;
    iAddr0 = 32'd0; iAddr1 = 32'd0; iWData0 = 32'd0; iWData1 = 32'd0; iMemRData = 32'd0;
    @(negedge iCLK);
    do_reset();

    // Read by requester 0; address change and request drop mid-access are ignored.
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h100; iMemRData = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin cg[i] = 0; cs[i] = 0; ca[i] = 0; co[i] = 0; end
    for (int c = 0; c < 13; c++) begin
      cycle();
      if (c == 0) begin iAddr0 = 32'h999; iReq0 = 1'b0; end
      for (int i = 0; i < 3; i++) begin
        cg[i] += int'(g0[i]); cs[i] += int'(mre[i]); ca[i] += int'(a0[i]); co[i] += int'(mwe[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("u%0d read gnt width", i), 32'(cg[i]), 32'(RDL[i] + 1));
      cmp($sformatf("u%0d read re width", i), 32'(cs[i]), 32'(RDL[i]));
      cmp($sformatf("u%0d read ack count", i), 32'(ca[i]), 32'd1);
      cmp($sformatf("u%0d read we count", i), 32'(co[i]), 32'd0);
      cmp($sformatf("u%0d read data", i), r0[i], 32'hDEADBEEF);
    end

    // Write by requester 1; its read-data register must not change.
    iReq1 = 1'b1; iWe1 = 1'b1; iAddr1 = 32'h200; iWData1 = 32'h12345678; iMemRData = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin cg[i] = 0; cs[i] = 0; ca[i] = 0; co[i] = 0; end
    for (int c = 0; c < 13; c++) begin
      cycle();
      if (c == 0) iReq1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cg[i] += int'(g1[i]); cs[i] += int'(mwe[i]); ca[i] += int'(a1[i]); co[i] += int'(mre[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("u%0d write gnt width", i), 32'(cg[i]), 32'(WRL[i] + 1));
      cmp($sformatf("u%0d write we width", i), 32'(cs[i]), 32'(WRL[i]));
      cmp($sformatf("u%0d write ack count", i), 32'(ca[i]), 32'd1);
      cmp($sformatf("u%0d write re count", i), 32'(co[i]), 32'd0);
      cmp($sformatf("u%0d write rdata1 kept", i), r1[i], 32'd0);
    end

    // Both requesters held high from reset: grants must alternate 0,1,0,1.
    do_reset();
    iReq0 = 1'b1; iReq1 = 1'b1; iWe0 = 1'b0; iWe1 = 1'b0;
    prev_own = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cycle();
      if ((g0[0] | g1[0]) && !prev_own) order.push_back(g1[0]);
      prev_own = g0[0] | g1[0];
    end
    cmp("rr grant count", 32'(order.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) cmp($sformatf("rr grant %0d", k), 32'(order[k]), 32'(k % 2));
    end
    iReq0 = 1'b0; iReq1 = 1'b0;

    // Reset in the second BUSY cycle of a write aborts it with no ack.
    do_reset();
    iReq0 = 1'b1; iWe0 = 1'b1; iAddr0 = 32'h300; iWData0 = 32'hA5A5A5A5;
    cycle();
    iReq0 = 1'b0;
    cycle();
    cmp("abort we before reset", 32'(mwe[0]), 32'd1);
    iRST = 1'b1;
    #1;
    cmp("abort we async drop", 32'(mwe[0]), 32'd0);
    cmp("abort state", 32'(st[0]), 32'd0);
    model_reset();
    check_all();
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) ca[i] = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) ca[i] += int'(a0[i]);
    end
    cmp("abort no ack", 32'(ca[0]), 32'd0);
    iReq1 = 1'b1; iWe1 = 1'b0; iAddr1 = 32'h44; iMemRData = 32'h0BADCAFE;
    for (int i = 0; i < 3; i++) ca[i] = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (c == 0) iReq1 = 1'b0;
      for (int i = 0; i < 3; i++) ca[i] += int'(a1[i]);
    end
    cmp("post-abort ack", 32'(ca[0]), 32'd1);
    cmp("post-abort rdata1", r1[0], 32'h0BADCAFE);

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        iReq0     = ($urandom_range(2) != 0);
        iReq1     = ($urandom_range(2) != 0);
        iWe0      = $urandom_range(1) == 1;
        iWe1      = $urandom_range(1) == 1;
        iAddr0    = $urandom;
        iAddr1    = $urandom;
        iWData0   = $urandom;
        iWData1   = $urandom;
        iMemRData = $urandom;
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
